set_scanner: RTL and testbench
==============================

SET_SCANNER -- requirements
Module: set_scanner

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk_i and rst_i.
REQ-002 clk_i  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_i  input  1  asynchronous active-high reset.
REQ-004 start_i  input  1  request to evaluate one SET problem; sampled only in IDLE.
REQ-005 mode_i  input  2  operation select; captured on start acceptance.
REQ-006 central_buf_i  input  `CENTRAL_SZ (24)  held centers from the input buffer: x1=[23:20], y1=[19:16], x2=[15:12], y2=[11:8], x3=[7:4], y3=[3:0].
REQ-007 r_buf_i  input  `RADIUS_SZ (12)  held radii from the input buffer: rA=[11:8], rB=[7:4], rC=[3:0].
REQ-008 buffer_en_o  output  1  load strobe to the input buffer; combinational, high only when start_i=1 in IDLE.
REQ-009 clear_o  output  1  active-low clear to the input buffer; low for exactly the DONE cycle, otherwise high.
REQ-010 busy_o  output  1  high in LOAD, SCAN and DONE.
REQ-011 valid_o  output  1  one-cycle pulse in DONE; marks candidate_o as the new result.
REQ-012 candidate_o  output  8  registered count of grid points satisfying the mode.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, SCAN and DONE.
REQ-014 IDLE->LOAD SHALL occur on start_i=1; mode_i SHALL be latched and the point counter SHALL clear to 0 on the same edge.
REQ-015 LOAD SHALL last one cycle, during which the buffer outputs settle; LOAD->SCAN is unconditional.
REQ-016 SCAN SHALL visit grid points (x,y) with x,y in 1..8, one point per cycle, x incrementing fastest from (1,1) to (8,8), for 64 cycles in total.
REQ-017 Membership in circle k SHALL be (x-xk)^2+(y-yk)^2 <= rk^2.
REQ-018 The differences SHALL be computed as 5-bit signed values, the sum of squares at 9 bits unsigned and rk^2 zero-extended to 9 bits, so that no overflow occurs for centers 0..15 and radii 0..15.
REQ-019 Point qualification SHALL be: mode 00 = in A; 01 = in A and in B; 10 = in exactly one of A and B; 11 = in exactly two of A, B and C.
REQ-020 The counter SHALL be 7 bits wide, increment once per qualifying point, and never wrap (maximum 64).
REQ-021 After point (8,8), SCAN->DONE SHALL occur; in DONE, candidate_o SHALL load the final count, valid_o=1 and clear_o=0.
REQ-022 DONE->IDLE SHALL be unconditional.
REQ-023 candidate_o SHALL hold its value until the next DONE.
REQ-024 Start-to-valid latency SHALL be 66 cycles: start accepted at edge T gives LOAD at T+1, SCAN at T+2..T+65 and DONE at T+66.
REQ-025 start_i SHALL be ignored while busy_o=1, and buffer_en_o SHALL stay low while busy_o=1.
REQ-026 start_i=1 in the DONE cycle SHALL NOT be accepted; it is accepted only once the FSM is back in IDLE.
REQ-027 mode_i changes after acceptance SHALL NOT affect the result in progress.
REQ-028 Centers outside 1..8 SHALL be evaluated arithmetically without special handling.

Reset
REQ-029 While rst_i=1, at any time including mid-SCAN, the block SHALL immediately enter IDLE.
REQ-030 While rst_i=1, the outputs SHALL be: busy_o=0, valid_o=0, clear_o=1, buffer_en_o=0 and candidate_o=0.
REQ-031 While rst_i=1, the counter, point index and latched mode SHALL be 0.
REQ-032 A scan interrupted by reset SHALL produce no valid_o pulse.
REQ-033 After reset release, the first start_i SHALL be accepted normally.

Verification
REQ-034 mode 00, A=(4,4), rA=2 -> valid_o at T+66, candidate_o=13, clear_o low that cycle only.
REQ-035 mode 00, A=(8,8), rA=15 -> candidate_o=64; mode 00, A=(1,1), rA=0 -> candidate_o=1.
REQ-036 A=B=(4,4), rA=rB=2: mode 01 -> 13; mode 10 -> 0; mode 11 with C=(15,15), rC=0 -> 13.
REQ-037 start_i held high continuously -> exactly one acceptance per 67-cycle period, buffer_en_o high only in IDLE cycles, and mode_i toggled mid-scan has no effect on the result.
REQ-038 rst_i pulsed at SCAN cycle 30 -> immediate IDLE with all outputs at reset values, no valid_o; the next start then gives the correct count.

Source files
------------

// File: rtl/set_scanner_if.sv
// Handshake and buffer bus between the SET problem input buffer/requester and set_scanner.
// Signal names keep the scanner's point of view (_i into the scanner, _o out of it).
interface set_scanner_if #(
  parameter int unsigned CentralSz = 24,
  parameter int unsigned RadiusSz  = 12
);
  logic                 start_i;
  logic [1:0]           mode_i;
  logic [CentralSz-1:0] central_buf_i;
  logic [RadiusSz-1:0]  r_buf_i;
  logic                 buffer_en_o;
  logic                 clear_o;
  logic                 busy_o;
  logic                 valid_o;
  logic [7:0]           candidate_o;

  modport master (
    output start_i, mode_i, central_buf_i, r_buf_i,
    input  buffer_en_o, clear_o, busy_o, valid_o, candidate_o
  );

  modport slave (
    input  start_i, mode_i, central_buf_i, r_buf_i,
    output buffer_en_o, clear_o, busy_o, valid_o, candidate_o
  );
endinterface

// File: rtl/set_scanner.sv
// Scans the 8x8 grid one point per cycle and counts points that satisfy the selected
// membership rule over three circles A, B, C; result is presented with a one-cycle valid pulse.
module set_scanner (
  input  logic         clk_i,
  input  logic         rst_i,
  set_scanner_if.slave bus_io
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StScan = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [6:0] CntMax = 7'd64;

  logic [1:0] state_q, state_d;
  logic [1:0] mode_q,  mode_d;
  logic [6:0] cnt_q,   cnt_d;
  logic [5:0] pt_q,    pt_d;
  logic [7:0] cand_q,  cand_d;

  logic [3:0] x1, y1, x2, y2, x3, y3;
  logic [3:0] ra, rb, rc;
  logic [3:0] px, py;
  logic       in_a, in_b, in_c;
  logic       hit;
  logic [6:0] cnt_inc;

  assign x1 = bus_io.central_buf_i[23:20];
  assign y1 = bus_io.central_buf_i[19:16];
  assign x2 = bus_io.central_buf_i[15:12];
  assign y2 = bus_io.central_buf_i[11:8];
  assign x3 = bus_io.central_buf_i[7:4];
  assign y3 = bus_io.central_buf_i[3:0];
  assign ra = bus_io.r_buf_i[11:8];
  assign rb = bus_io.r_buf_i[7:4];
  assign rc = bus_io.r_buf_i[3:0];

  // Point index runs 0..63; low three bits are x-1 so x advances fastest.
  assign px = {1'b0, pt_q[2:0]} + 4'd1;
  assign py = {1'b0, pt_q[5:3]} + 4'd1;

  // 5-bit signed differences, 8-bit squares, 9-bit sum: worst case 14^2+14^2=392 fits.
  function automatic logic [8:0] dist_sq(input logic [3:0] ax, input logic [3:0] ay,
                                         input logic [3:0] cx, input logic [3:0] cy);
    logic signed [4:0] dx, dy;
    logic [4:0]        mx, my;
    logic [7:0]        sx, sy;
    dx = $signed({1'b0, ax}) - $signed({1'b0, cx});
    dy = $signed({1'b0, ay}) - $signed({1'b0, cy});
    mx = dx[4] ? $unsigned(-dx) : $unsigned(dx);
    my = dy[4] ? $unsigned(-dy) : $unsigned(dy);
    sx = {3'b000, mx} * {3'b000, mx};
    sy = {3'b000, my} * {3'b000, my};
    return {1'b0, sx} + {1'b0, sy};
  endfunction

  function automatic logic [8:0] rad_sq(input logic [3:0] r);
    logic [7:0] sq;
    sq = {4'h0, r} * {4'h0, r};
    return {1'b0, sq};
  endfunction

  assign in_a = dist_sq(px, py, x1, y1) <= rad_sq(ra);
  assign in_b = dist_sq(px, py, x2, y2) <= rad_sq(rb);
  assign in_c = dist_sq(px, py, x3, y3) <= rad_sq(rc);

  always_comb begin
    hit = 1'b0;
    unique case (mode_q)
      2'b00:   hit = in_a;
      2'b01:   hit = in_a & in_b;
      2'b10:   hit = in_a ^ in_b;
      2'b11:   hit = (in_a & in_b & ~in_c) | (in_a & ~in_b & in_c) | (~in_a & in_b & in_c);
      default: hit = 1'b0;
    endcase
  end

  // Saturating increment; 64 points can never exceed CntMax but the guard keeps it explicit.
  assign cnt_inc = (hit && (cnt_q != CntMax)) ? cnt_q + 7'd1 : cnt_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    pt_d    = pt_q;
    cand_d  = cand_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start_i) begin
          state_d = StLoad;
          mode_d  = bus_io.mode_i;
          cnt_d   = 7'd0;
          pt_d    = 6'd0;
        end
      end
      StLoad: begin
        state_d = StScan;
      end
      StScan: begin
        cnt_d = cnt_inc;
        pt_d  = pt_q + 6'd1;
        // Result is registered on the way into DONE so it lines up with valid_o.
        if (pt_q == 6'd63) begin
          state_d = StDone;
          cand_d  = {1'b0, cnt_inc};
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      mode_q  <= 2'b00;
      cnt_q   <= 7'd0;
      pt_q    <= 6'd0;
      cand_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      pt_q    <= pt_d;
      cand_q  <= cand_d;
    end
  end

  // rst_i gates the load strobe so it is low for the whole reset, not just after an edge.
  assign bus_io.buffer_en_o = (state_q == StIdle) && bus_io.start_i && !rst_i;
  assign bus_io.busy_o      = (state_q != StIdle);
  assign bus_io.valid_o     = (state_q == StDone);
  assign bus_io.clear_o     = (state_q != StDone);
  assign bus_io.candidate_o = cand_q;

endmodule

// File: tb/tb_set_scanner.sv
// Scoreboard bench for set_scanner: stimulus queues expected counts, a monitor branch
// pops them on valid_o and also checks latency, clear_o timing and buffer_en_o gating.
module tb_set_scanner;

  logic        clk_i = 1'b0;
  logic        rst_i;
  int unsigned cyc = 0;

  set_scanner_if bus ();

  set_scanner dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .bus_io (bus.slave)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_q[$];
  int unsigned acc_q[$];
  bit          done = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] pack_c(input int ax, input int ay, input int bx,
                                         input int by, input int cx, input int cy);
    return {4'(ax), 4'(ay), 4'(bx), 4'(by), 4'(cx), 4'(cy)};
  endfunction

  function automatic logic [11:0] pack_r(input int ra, input int rb, input int rc);
    return {4'(ra), 4'(rb), 4'(rc)};
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy_o) break;
      @(posedge clk_i);
      #1;
    end
    check("idle_timeout", int'(bus.busy_o), 0);
  endtask

  task automatic run(input logic [1:0] m, input logic [23:0] c, input logic [11:0] r,
                     input int exp);
    @(posedge clk_i);
    #1;
    bus.mode_i        = m;
    bus.central_buf_i = c;
    bus.r_buf_i       = r;
    bus.start_i       = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk_i);
    #1;
    bus.start_i = 1'b0;
    bus.mode_i  = ~m;   // must not leak into the scan in progress
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},   int'(bus.busy_o),      0);
    check({tag, "_valid"},  int'(bus.valid_o),     0);
    check({tag, "_clear"},  int'(bus.clear_o),     1);
    check({tag, "_bufen"},  int'(bus.buffer_en_o), 0);
    check({tag, "_cand"},   int'(bus.candidate_o), 0);
  endtask

  task automatic monitor();
    bit prev_valid = 1'b0;
    int last_cand  = 0;
    int e;
    int unsigned a;
    while (!done) begin
      @(negedge clk_i);
      if (rst_i) begin
        acc_q.delete();
        prev_valid = 1'b0;
        continue;
      end
      if (bus.busy_o) check("bufen_while_busy", int'(bus.buffer_en_o), 0);
      if (prev_valid) begin
        check("clear_after_done", int'(bus.clear_o), 1);
        check("valid_one_cycle",  int'(bus.valid_o), 0);
        check("cand_hold",        int'(bus.candidate_o), last_cand);
      end
      if (bus.valid_o) begin
        check("clear_low_in_done", int'(bus.clear_o), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("candidate", int'(bus.candidate_o), e);
          last_cand = e;
        end
        if (acc_q.size() == 0) begin
          check("valid_without_accept", 1, 0);
        end else begin
          a = acc_q.pop_front();
          check("latency", int'(cyc - a), 66);
        end
      end
      if (bus.buffer_en_o) acc_q.push_back(cyc);
      prev_valid = bus.valid_o;
    end
  endtask

  task automatic stimulus();
    // Reset, with start_i high to prove buffer_en_o is gated.
    rst_i             = 1'b1;
    bus.start_i       = 1'b1;
    bus.mode_i        = 2'b11;
    bus.central_buf_i = '0;
    bus.r_buf_i       = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("rst0");
    bus.start_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    run(2'b00, pack_c(4, 4, 0, 0, 0, 0),     pack_r(2, 0, 0),   13);
    run(2'b00, pack_c(8, 8, 0, 0, 0, 0),     pack_r(15, 0, 0),  64);
    run(2'b00, pack_c(1, 1, 0, 0, 0, 0),     pack_r(0, 0, 0),   1);
    run(2'b01, pack_c(4, 4, 4, 4, 0, 0),     pack_r(2, 2, 0),   13);
    run(2'b10, pack_c(4, 4, 4, 4, 0, 0),     pack_r(2, 2, 0),   0);
    run(2'b11, pack_c(4, 4, 4, 4, 15, 15),   pack_r(2, 2, 0),   13);
    run(2'b10, pack_c(2, 2, 7, 7, 0, 0),     pack_r(1, 1, 0),   10);
    run(2'b11, pack_c(2, 2, 2, 2, 7, 7),     pack_r(1, 1, 1),   5);
    run(2'b11, pack_c(4, 4, 4, 4, 4, 4),     pack_r(2, 2, 1),   8);
    run(2'b00, pack_c(0, 0, 0, 0, 0, 0),     pack_r(2, 0, 0),   1);
    run(2'b00, pack_c(12, 4, 0, 0, 0, 0),    pack_r(5, 0, 0),   8);
    run(2'b00, pack_c(15, 15, 0, 0, 0, 0),   pack_r(15, 0, 0),  32);

    // start_i held high: two back-to-back acceptances; mode toggled mid-scan.
    @(posedge clk_i);
    #1;
    bus.central_buf_i = pack_c(4, 4, 1, 1, 0, 0);
    bus.r_buf_i       = pack_r(2, 0, 0);
    bus.mode_i        = 2'b00;
    bus.start_i       = 1'b1;
    exp_q.push_back(13);
    exp_q.push_back(13);
    repeat (30) @(posedge clk_i);
    #1;
    bus.mode_i = 2'b01;
    repeat (10) @(posedge clk_i);
    #1;
    bus.mode_i = 2'b00;
    repeat (37) @(posedge clk_i);
    #1;
    bus.start_i = 1'b0;
    wait_idle();

    // Reset at SCAN cycle 30: immediate idle, no valid_o for the aborted scan.
    @(posedge clk_i);
    #1;
    bus.central_buf_i = pack_c(4, 4, 0, 0, 0, 0);
    bus.r_buf_i       = pack_r(2, 0, 0);
    bus.mode_i        = 2'b00;
    bus.start_i       = 1'b1;
    @(posedge clk_i);
    #1;
    bus.start_i = 1'b0;
    repeat (31) @(posedge clk_i);
    #2;
    check("busy_before_abort", int'(bus.busy_o), 1);
    rst_i       = 1'b1;
    bus.start_i = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk_i);
    #1;
    check_reset_outputs("rst_hold");
    bus.start_i = 1'b0;
    rst_i       = 1'b0;
    repeat (70) @(posedge clk_i);
    #1;
    check("idle_after_abort", int'(bus.busy_o), 0);

    run(2'b00, pack_c(4, 4, 0, 0, 0, 0), pack_r(2, 0, 0), 13);
    repeat (3) @(posedge clk_i);
    done = 1'b1;
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join
    check("exp_q_drained", exp_q.size(), 0);
    check("acc_q_drained", acc_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "global timeout");
  end

endmodule
